// File: rtl/down_timer_pkg.sv
// Shared definitions for the 4-bit down timer: state encodings and decode helpers.
// Used by both the RTL and the testbench.
package down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic state_is_busy(state_t s);
    return (s == RUN);
  endfunction

  function automatic logic state_is_done(state_t s);
    return (s == DONE);
  endfunction

endpackage

// File: rtl/decrementor_nb.sv
// Combinational N-bit decrementor: out = in - 1 (modulo 2^WIDTH), bout flags a borrow (in == 0).
module decrementor_nb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             bout
);

  assign out  = in - {{(WIDTH-1){1'b0}}, 1'b1};
  assign bout = (in == '0);

endmodule

// File: rtl/down_timer_4b.sv
// Loadable down timer with IDLE/RUN/DONE handshake and a one-cycle terminal-count pulse.
// Optional auto-reload on terminal count when DOWN_TIMER_RELOAD_EN is defined.
module down_timer_4b
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             tick,
  input  logic             ack,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted only in IDLE, ack only in DONE, tick only in RUN;
  // each is a level sampled on the rising edge, and abort overrides all of them.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] dec_out;
  logic             dec_bout;
  logic             at_one;

  decrementor_nb #(.WIDTH(WIDTH)) u_dec (
    .in   (count_q),
    .out  (dec_out),
    .bout (dec_bout)
  );

  // count_q - 1 == 0 without a borrow means count_q == 1
  assign at_one = ~dec_bout & (dec_out == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            count_d = load_val;
            if (load_val != '0) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              tc_d    = 1'b1;
            end
          end
        end
        RUN: begin
          if (tick) begin
            if (at_one) begin
              tc_d = 1'b1;
`ifdef DOWN_TIMER_RELOAD_EN
              if (load_val != '0) begin
                count_d = load_val;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
`else
              count_d = '0;
              state_d = DONE;
`endif
            end else begin
              count_d = dec_out;
            end
          end
        end
        DONE: begin
          count_d = '0;
          if (ack) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign busy      = state_is_busy(state_q);
  assign done      = state_is_done(state_q);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_down_timer_4b.sv
// Directed testbench for down_timer_4b: reset, countdown, tick gating, zero load,
// abort, asynchronous reset and terminal-count / reload behaviour.
module tb_down_timer_4b;
  import down_timer_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] load_val;
  logic         start;
  logic         tick;
  logic         ack;
  logic         abort;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  int vectors;
  int miscompares;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_c;
  logic [6:0]   obs;
  logic [6:0]   exp_v;

  down_timer_4b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_val  (load_val),
    .start     (start),
    .tick      (tick),
    .ack       (ack),
    .abort     (abort),
    .count     (count),
    .tc        (tc),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    tick     = 1'b0;
    ack      = 1'b0;
    abort    = 1'b0;
    load_val = '0;
  endtask

  // observed vector layout: {count, tc, busy, done}
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b want=%b", obs, exp_v);
    end
    step();
    step();
    rst = 1'b0;
    tick = 1'b1;
    step();
    step();
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp_v || state_dbg !== 2'(IDLE)) begin
      miscompares++;
      $display("FAIL idle_ignores_tick got=%b st=%0d want=%b st=0", obs, state_dbg, exp_v);
    end
    tick = 1'b0;
  endtask

  task automatic test_countdown();
    idle_inputs();
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd1);
    load_val = 4'd3;
    start    = 1'b1;
    tick     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      exp_c = exp_q.pop_front();
      obs = {count, tc, busy, done};
      exp_v = {exp_c, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL countdown_run[%0d] got=%b want=%b", i, obs, exp_v);
      end
    end
    step();
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b1, 1'b0, 1'b1};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL countdown_terminal got=%b want=%b", obs, exp_v);
    end
    step();
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL done_hold got=%b want=%b", obs, exp_v);
    end
    ack = 1'b1;
    step();
    ack  = 1'b0;
    tick = 1'b0;
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL ack_to_idle got=%b want=%b", obs, exp_v);
    end
  endtask

  task automatic test_tick_gating();
    logic tick_pat [5];
    idle_inputs();
    tick_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd4);
    exp_q.push_back(4'd4);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd3);
    load_val = 4'd5;
    start    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick = tick_pat[i];
      step();
      // start held and load_val changed while running: must be ignored
      load_val = 4'd9;
      exp_c = exp_q.pop_front();
      obs = {count, tc, busy, done};
      exp_v = {exp_c, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL tick_gating[%0d] got=%b want=%b", i, obs, exp_v);
      end
    end
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_zero_load();
    idle_inputs();
    load_val = 4'd0;
    start    = 1'b1;
    step();
    start = 1'b0;
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b1, 1'b0, 1'b1};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL zero_load got=%b want=%b", obs, exp_v);
    end
    ack      = 1'b1;
    start    = 1'b1;
    load_val = 4'd4;
    step();
    ack   = 1'b0;
    start = 1'b0;
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp_v || state_dbg !== 2'(IDLE)) begin
      miscompares++;
      $display("FAIL ack_start_same_cycle got=%b st=%0d want=%b st=0", obs, state_dbg, exp_v);
    end
    step();
    obs = {count, tc, busy, done};
    vectors++;
    if (obs !== exp_v || state_dbg !== 2'(IDLE)) begin
      miscompares++;
      $display("FAIL start_not_latched got=%b st=%0d want=%b st=0", obs, state_dbg, exp_v);
    end
  endtask

  task automatic test_abort();
    idle_inputs();
    load_val = 4'd4;
    start    = 1'b1;
    tick     = 1'b0;
    step();
    start = 1'b0;
    tick  = 1'b1;
    step();
    step();
    obs = {count, tc, busy, done};
    exp_v = {4'd2, 1'b0, 1'b1, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL abort_setup got=%b want=%b", obs, exp_v);
    end
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    tick  = 1'b0;
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL abort_in_run got=%b want=%b", obs, exp_v);
    end
    // abort in DONE beats ack and returns to IDLE
    load_val = 4'd0;
    start    = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b1;
    ack   = 1'b1;
    step();
    abort = 1'b0;
    ack   = 1'b0;
    obs = {count, tc, busy, done};
    vectors++;
    if (obs !== exp_v || state_dbg !== 2'(IDLE)) begin
      miscompares++;
      $display("FAIL abort_in_done got=%b st=%0d want=%b st=0", obs, state_dbg, exp_v);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    load_val = 4'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    tick  = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL async_reset_mid_run got=%b want=%b", obs, exp_v);
    end
    tick = 1'b0;
    step();
    rst      = 1'b0;
    load_val = 4'd2;
    start    = 1'b1;
    step();
    start = 1'b0;
    obs = {count, tc, busy, done};
    exp_v = {4'd2, 1'b0, 1'b1, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL resume_after_reset got=%b want=%b", obs, exp_v);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

`ifdef DOWN_TIMER_RELOAD_EN
  task automatic test_terminal();
    logic exp_tc [5];
    idle_inputs();
    exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    load_val = 4'd2;
    start    = 1'b1;
    tick     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start = 1'b0;
      exp_c = exp_q.pop_front();
      obs = {count, tc, busy, done};
      exp_v = {exp_c, exp_tc[i], 1'b1, 1'b0};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reload[%0d] got=%b want=%b", i, obs, exp_v);
      end
    end
    load_val = 4'd0;
    step();
    step();
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b1, 1'b0, 1'b1};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL reload_zero_done got=%b want=%b", obs, exp_v);
    end
    tick = 1'b0;
    ack  = 1'b1;
    step();
    ack = 1'b0;
  endtask
`else
  task automatic test_terminal();
    idle_inputs();
    load_val = 4'd1;
    start    = 1'b1;
    tick     = 1'b1;
    step();
    start = 1'b0;
    obs = {count, tc, busy, done};
    exp_v = {4'd1, 1'b0, 1'b1, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL load_one got=%b want=%b", obs, exp_v);
    end
    step();
    obs = {count, tc, busy, done};
    exp_v = {4'd0, 1'b1, 1'b0, 1'b1};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL one_to_done got=%b want=%b", obs, exp_v);
    end
    tick = 1'b0;
    ack  = 1'b1;
    step();
    ack = 1'b0;
  endtask
`endif

  task automatic test_max_load();
    idle_inputs();
    load_val = 4'd15;
    start    = 1'b1;
    step();
    start = 1'b0;
    tick  = 1'b1;
    for (int i = 0; i < 14; i++) step();
    obs = {count, tc, busy, done};
    exp_v = {4'd1, 1'b0, 1'b1, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL max_load_at_one got=%b want=%b", obs, exp_v);
    end
    tick = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    idle_inputs();
    test_reset();
    test_countdown();
    test_tick_gating();
    test_zero_load();
    test_abort();
    test_async_reset();
    test_terminal();
    test_max_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/down_timer_4b.md
DOWN_TIMER_4B -- requirements
Module: down_timer_4b

Interface
REQ-001 SHALL provide parameter: WIDTH, 4, counter width in bits (>=2).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: load_val  input  WIDTH  countdown start value.
REQ-005 SHALL provide port: start  input  1  countdown request, sampled in IDLE only.
REQ-006 SHALL provide port: tick  input  1  decrement qualifier, sampled in RUN only.
REQ-007 SHALL provide port: ack  input  1  done acknowledge, sampled in DONE only.
REQ-008 SHALL provide port: abort  input  1  cancel countdown, highest-priority input.
REQ-009 SHALL provide port: count  output  WIDTH  current count value, registered.
REQ-010 SHALL provide port: tc  output  1  terminal-count pulse, registered.
REQ-011 SHALL provide port: busy  output  1  high while state is RUN.
REQ-012 SHALL provide port: done  output  1  high while state is DONE.

Function
REQ-013 SHALL implement three states: IDLE, RUN and DONE. busy and done SHALL be decoded from state, never both high.
REQ-014 IDLE with start=1 SHALL load count<=load_val at that edge and go to RUN if load_val!=0, else to DONE with tc=1.
REQ-015 RUN with tick=1 SHALL set count<=count-1 modulo 2^WIDTH. RUN with tick=0 SHALL hold count.
REQ-016 RUN with tick=1 and count==1 SHALL set count<=0, assert tc for exactly that next cycle and go to DONE.
REQ-017 start SHALL be ignored in RUN and DONE. tick SHALL be ignored in IDLE and DONE.
REQ-018 DONE SHALL hold count=0. ack=1 SHALL return to IDLE with count held at 0.
REQ-019 DONE with ack=1 and start=1 in the same cycle SHALL go to IDLE only; start must be re-presented.
REQ-020 abort=1 in any state SHALL go to IDLE next edge with count<=0 and tc=0, overriding start, tick and ack.
REQ-021 tc SHALL be 0 in every cycle not named in REQ-014, REQ-016 or REQ-024.
REQ-022 Latency SHALL be: start to busy, 1 cycle; last tick to done, 1 cycle; ack to done low, 1 cycle.

Reset
REQ-023 rst=1 SHALL immediately, without a clock edge, force state=IDLE, count=0, tc=0, busy=0 and done=0, including mid-RUN. Operation SHALL resume on the first edge after rst falls.

Configuration
REQ-024 With macro DOWN_TIMER_RELOAD_EN defined, REQ-016 SHALL change as follows:
- count<=load_val, sampled at that edge; state remains RUN; tc pulses for one cycle.
- If load_val==0 at that edge, the block SHALL go to DONE per REQ-016 instead.
REQ-025 Without DOWN_TIMER_RELOAD_EN, behaviour SHALL be exactly REQ-016, with no reload logic synthesized.

Structure
REQ-026 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL reside in shared package down_timer_pkg, for use by RTL and bench.
REQ-027 The decrement SHALL be a combinational sub-module decrementor_nb (in WIDTH, out=in-1, bout=1 iff in==0). down_timer_4b SHALL instantiate it once.

Verification
REQ-028 rst pulse, load_val=3, start 1 cycle, tick=1 held:
- count goes 3,2,1,0 on successive edges.
- busy=1 for 3 cycles.
- tc=1 and done=1 together when count=0.
- ack then gives done=0 and busy=0.
REQ-029 load_val=5, tick toggling 1,0,1,0:
- count goes 5,4,4,3,3.
- tc=0 throughout.
REQ-030 load_val=0 with start:
- next cycle done=1, tc=1, count=0, busy=0.
- ack=1 together with start=1 gives IDLE, and count stays 0 the following cycle.
REQ-031 abort=1 in RUN at count=2:
- next cycle busy=0, done=0, count=0, tc=0.
- With rst=1 asserted mid-RUN between edges, all outputs are 0 before the next edge.
REQ-032 With DOWN_TIMER_RELOAD_EN, load_val=2, tick=1 held:
- count goes 2,1,2,1,2.
- tc pulses on every reload, and done stays 0.
- Then load_val=0 before the next reload gives done=1.
